// File: rtl/array_west_sequencer.sv
// West-edge driver for the OS/WS MAC array: takes one command plus row-wide data beats
// and emits per-row in_w/inst_w, with row r delayed r cycles relative to row 0.
module array_west_sequencer #(
  parameter int bw     = 4,
  parameter int row    = 8,
  parameter int len_bw = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [len_bw-1:0]   cmd_len,
  input  logic                data_valid,
  output logic                data_ready,
  input  logic [row*bw-1:0]   data_in,
  output logic [row*bw-1:0]   out_w,
  output logic [row*3-1:0]    inst_w,
  output logic                busy,
  output logic                done
);

  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // ISSUE | launching beats (data handshakes, or one per cycle for flush)
  // DRAIN | last beat walking down the skew lines; done when it reaches row-1
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

  localparam int dw = $clog2(row) + 1;
  localparam logic [dw-1:0] drain_last = dw'(row - 1);

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [len_bw-1:0]   len_q, len_d;
  logic [len_bw-1:0]   beat_q, beat_d;
  logic [dw-1:0]       drain_q, drain_d;
  logic                beat_fire;
  logic                last_beat;
  logic [row*bw-1:0]   inj_data;
  logic [2:0]          inj_inst;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    len_d     = len_q;
    beat_d    = beat_q;
    drain_d   = drain_q;
    beat_fire = (state_q == ISSUE) && ((op_q == 2'b11) || data_valid);
    last_beat = beat_fire && (beat_q == (len_q - len_bw'(1)));
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          len_d  = cmd_len;
          beat_d = '0;
          if (cmd_len == '0) begin
            // nothing to issue: land directly on the done cycle
            state_d = DRAIN;
            drain_d = drain_last;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (beat_fire) begin
          beat_d = beat_q + len_bw'(1);
          if (last_beat) begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end
      end
      DRAIN: begin
        if (drain_q == drain_last) state_d = IDLE;
        else                       drain_d = drain_q + dw'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = (state_q == IDLE);
    data_ready = (state_q == ISSUE) && (op_q != 2'b11);
    busy       = (state_q != IDLE);
    done       = (state_q == DRAIN) && (drain_q == drain_last);
    inj_data   = '0;
    inj_inst   = 3'b000;
    if (state_q == ISSUE) begin
      if (op_q == 2'b11) begin
        inj_inst = 3'b101;
      end else if (data_valid) begin
        inj_data = data_in;
        case (op_q)
          2'b00:   inj_inst = 3'b001;
          2'b01:   inj_inst = 3'b010;
          default: inj_inst = 3'b110;
        endcase
      end else begin
        inj_inst = {op_q[1], 2'b00};
      end
    end
  end

  for (genvar r = 0; r < row; r++) begin : g_lane
    localparam int dlw = (r + 1) * bw;
    localparam int ilw = (r + 1) * 3;
    logic [dlw-1:0] dly_data_q, dly_data_d;
    logic [ilw-1:0] dly_inst_q, dly_inst_d;

    always_comb begin
      dly_data_d = (dly_data_q << bw) | dlw'(inj_data[r*bw +: bw]);
      dly_inst_d = (dly_inst_q << 3) | ilw'(inj_inst);
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        dly_data_q <= '0;
        dly_inst_q <= '0;
      end else begin
        dly_data_q <= dly_data_d;
        dly_inst_q <= dly_inst_d;
      end
    end

    assign out_w[r*bw +: bw] = dly_data_q[dlw-1 -: bw];
    assign inst_w[r*3 +: 3]  = dly_inst_q[ilw-1 -: 3];
  end

endmodule

// File: doc/array_west_sequencer.md
Name: array_west_sequencer

Overview:
- Drives the west edge of the reconfigurable OS/WS MAC array: every row's activation/kernel bus and 3-bit instruction bus.
- Accepts one command plus a stream of row-wide data vectors through valid/ready handshakes.
- Emits per-row in_w/inst_w with the diagonal skew the array needs: row r is delayed r cycles relative to row 0.
- Sits between the L0/activation buffer and mac_array; it is the initiator side of the tile's inst_w/in_w interface.

Parameters:
bw, 4, activation/kernel element width
row, 8, number of array rows driven
len_bw, 8, width of command beat count

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low; low clears all state
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready
cmd_op  input  2  00 WS kernel load, 01 WS execute, 10 OS execute, 11 OS flush
cmd_len  input  len_bw  number of beats to issue
data_valid  input  1  data vector offered
data_ready  output  1  vector consumed when data_valid&&data_ready
data_in  input  row*bw  lane r = bits [bw*(r+1)-1 : bw*r]
out_w  output  row*bw  per-row in_w, lane r to array row r
inst_w  output  row*3  per-row inst_w {os, execute, kflush}, lane r bits [3r+2:3r]
busy  output  1  high whenever not IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, reset=0): state IDLE, beat counter 0, all delay-line registers 0, so out_w=0, inst_w=0, done=0, busy=0, data_ready=0. cmd_ready=1 once reset is released. Reset mid-command drops the command and clears in-flight skew data.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: cmd_ready=1. On accept, latch op and len and go to ISSUE. If len=0, go to DRAIN with zero beats.
- ISSUE: cmd_ready=0. For ops 00/01/10, data_ready=1 and a beat counts only on a data handshake. For op 11, data_ready=0 and one beat is counted every cycle. After the len-th beat, go to DRAIN.
- DRAIN: data_ready=0. Wait until the last beat's lane row-1 is on the outputs, assert done for that cycle, then return to IDLE.
- Instruction per beat:
  - 00 → 3'b001
  - 01 → 3'b010
  - 10 → 3'b110
  - 11 → 3'b101, with data lanes forced to 0
- Bubble (ISSUE, data op, no handshake): inject {os,2'b00} with data 0 and do not count it. os=1 for ops 10/11, else 0.
- Outside ISSUE, the injected stage value is 3'b000 with data 0.
- Skew: lane r has a delay line of r+1 registers. A beat launched at edge T (the handshake edge, or the cycle edge for flush) appears on out_w/inst_w lane r during the cycle after edge T+r. Lane 0 latency is 1 cycle.
- done: high exactly during the cycle lane row-1 of the final beat is presented, i.e. after edge T_last+row-1.
  - len=0: done is high during the cycle after the acceptance edge, with no non-zero inst emitted.
- A new command can be accepted in the cycle after done (IDLE). Back-to-back commands may differ in mode; draining guarantees no lane mixes two commands' instructions.
- Widths: the beat counter is len_bw bits and compares with the latched len, so there is no wrap. The drain counter is $clog2(row)+1 bits.
- Simultaneous cmd_valid and data_valid in IDLE: data is not consumed (data_ready=0 in IDLE).

Test Plan:
- Reset: pull reset low two cycles into an 8-beat WS execute → out_w/inst_w all 0 immediately; after release, busy=0, cmd_ready=1, and no done pulse.
- WS kernel load, row=8, len=8, continuous vectors with lane r of beat k = (k+r)%16, first handshake at edge 10 → lane r shows inst 001 and data (k+r)%16 in the cycle after edge 10+k+r; done high only in the cycle after edge 24.
- OS execute len=4 with data_valid pattern 1,0,1,0,1,0,1 → inst lane 0 sequence 110,100,110,100,110,100,110, exactly 4 data handshakes, done in the cycle after edge (last handshake + 7).
- OS flush len=8 → data_ready stays 0; every lane shows inst 101 for 8 consecutive cycles, skewed by r; out_w stays 0.
- cmd_len=0 (op 01) → done in the cycle after acceptance; inst_w stays 0 throughout.
- Hold cmd_valid with op 10 while busy from a prior WS load → cmd_ready=0 until the done cycle, accepted the cycle after; lane 7 never shows 001 and 110 in the same cycle.
